ecc_decode_ctrl: RTL
====================

# ecc_decode_ctrl

Sequencer that sits directly upstream of the Decoder in the error-correction accelerator. It accepts one decode command at a time from the register block, latches the codeword, injects the programmed noise pattern masked to the codeword width, and drives the Decoder's enable handshake. It then captures the Decoder's result into stable result registers and keeps saturating statistics of corrected and uncorrectable words.

## Interface
Parameters:
- AMBA_WORD, 32, width of the register-bus word and of dec_width
- DATA_WIDTH, 32, codeword/data width
- TIMEOUT, 15, max cycles in ISSUE waiting for dec_ready (4-bit counter)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle command strobe; sampled only in IDLE
- cw_width  in  2  00=8b, 01=16b, 10=32b, 11=illegal
- data_in  in  DATA_WIDTH  received codeword
- noise  in  DATA_WIDTH  error pattern XORed into codeword
- clr_stats  in  1  synchronous clear of statistics counters
- busy  out  1  high in any state other than IDLE
- dec_data_in  out  DATA_WIDTH  codeword presented to Decoder
- dec_width  out  AMBA_WORD  {zeros, latched cw_width}
- dec_en  out  1  Decoder enable
- dec_data_out  in  DATA_WIDTH  Decoder data result
- dec_num_of_error  in  2  Decoder error count
- dec_ready  in  1  Decoder result valid
- result_data  out  DATA_WIDTH  captured decoded data
- result_num_err  out  2  captured error count
- done  out  1  one-cycle pulse, result registers updated
- err  out  1  one-cycle pulse, command aborted (illegal width or timeout)
- cnt_single  out  16  saturating count of results with num_of_error=1
- cnt_double  out  16  saturating count of results with num_of_error=2

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, DONE, ABORT.
- IDLE: on start=1, latch cw_width. If cw_width=11, go to ABORT and leave dec_en low. Otherwise latch cw = (data_in ^ noise) & mask, where mask = 0x000000FF / 0x0000FFFF / 0xFFFFFFFF for 00/01/10. Clear the timeout counter and go to ISSUE.
- ISSUE: dec_en=1; dec_data_in and dec_width stay stable from the latched values. If dec_ready=1, go to CAPTURE. If the timeout counter equals TIMEOUT, go to ABORT. Otherwise increment the counter.
- CAPTURE: dec_en stays 1 so the Decoder output holds. Register dec_data_out into result_data and dec_num_of_error into result_num_err. Update statistics. Go to DONE.
- DONE: dec_en=0, done=1 for one cycle, then IDLE.
- ABORT: dec_en=0, err=1 for one cycle. Result registers and counters are unchanged. Then IDLE.
- start outside IDLE is ignored; there is no queueing.
- Statistics: increment by 1 and saturate at 0xFFFF. num_of_error 0 or 3 does not count. If clr_stats and an increment occur in the same cycle, clr_stats wins and the counter becomes 0.
- dec_data_in bits above the codeword width are always 0.

## Timing
- Reset: FSM in IDLE; busy, dec_en, done, err all 0; dec_data_in, dec_width, result_data, result_num_err, cnt_single, cnt_double all 0.
- Nominal latency, with the Decoder asserting ready one cycle after en:
  - start sampled at edge 0
  - ISSUE during cycle 1 (dec_en=1)
  - dec_ready seen in cycle 2, so CAPTURE in cycle 3
  - done=1 in cycle 4
  - busy high cycles 1-4
  - next start accepted at edge 5
- Timeout: err pulses TIMEOUT+2 cycles after the start edge when dec_ready never rises.
- Illegal width: err=1 in cycle 1; dec_en is never asserted.
- Reset asserted mid-operation: all outputs go to reset values immediately (asynchronous). No done or err pulse is produced.
- dec_ready arriving in the same cycle the counter reaches TIMEOUT: ready wins and the FSM goes to CAPTURE.

## Structure
- Shared package ecc_pkg holds:
  - cw_width encodings (CW8=2'b00, CW16=2'b01, CW32=2'b10)
  - state enum
  - mask constants
  - num_of_error encodings
- Sub-module sat_counter16 (increment, sync clear, saturate) is instantiated twice for the statistics.

## Test plan
- Clean 8-bit word: cw_width=00, data_in=0x000000F0, noise=0 → done at cycle 4 with result_data=Decoder output for codeword 0xF0; dec_data_in=0x000000F0; counters unchanged.
- Single-bit noise at 32 bits: cw_width=10, noise=0x80000000 → result_num_err=1, cnt_single=1. Repeat 65540 times → cnt_single saturates at 0xFFFF.
- Masking at 16 bits: cw_width=01, noise=0xFFFF0003 → dec_data_in[31:16]=0 and bits [1:0] flipped. With dec_num_of_error=2, cnt_double increments by 1.
- Illegal width: cw_width=11 → err pulse in cycle 1, dec_en never high, result registers unchanged, busy high exactly 1 cycle.
- Stuck Decoder: dec_ready tied 0 → err at cycle TIMEOUT+2 (17), dec_en low afterwards, FSM back in IDLE. A start issued while busy is ignored.
- Reset asserted during ISSUE, and clr_stats simultaneous with an increment in CAPTURE → all outputs return to 0 immediately; the counter reads 0 after the clash.

Source files
------------

// File: rtl/ecc_pkg.sv
// ecc_pkg: shared encodings for the ECC decode sequencer (widths, states, masks, error counts)
package ecc_pkg;
  localparam logic [1:0] CW8 = 2'b00;
  localparam logic [1:0] CW16 = 2'b01;
  localparam logic [1:0] CW32 = 2'b10;
  localparam logic [1:0] CW_ILL = 2'b11;
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_ISSUE = 3'd1;
  localparam state_t ST_CAPTURE = 3'd2;
  localparam state_t ST_DONE = 3'd3;
  localparam state_t ST_ABORT = 3'd4;
  localparam logic [31:0] MASK8 = 32'h0000_00FF;
  localparam logic [31:0] MASK16 = 32'h0000_FFFF;
  localparam logic [31:0] MASK32 = 32'hFFFF_FFFF;
  localparam logic [1:0] NE_NONE = 2'd0;
  localparam logic [1:0] NE_SINGLE = 2'd1;
  localparam logic [1:0] NE_DOUBLE = 2'd2;
  localparam logic [1:0] NE_FAIL = 2'd3;
  function automatic logic [31:0] width_mask(input logic [1:0] w);
    return w == CW8 ? MASK8 : w == CW16 ? MASK16 : MASK32;
  endfunction
endpackage

// File: rtl/sat_counter16.sv
// sat_counter16: 16-bit event counter that saturates at 0xFFFF; clr has priority over inc
// ports: clk, reset (async active-low), clr (sync clear), inc (count enable), count
module sat_counter16 (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else if (clr) count <= '0;
    else if (inc && count != 16'hFFFF) count <= count + 16'd1;
endmodule

// File: rtl/ecc_decode_ctrl.sv
// ecc_decode_ctrl: sequences one decode command into the Decoder, captures its result and keeps statistics
// ports: command side (start, cw_width, data_in, noise, clr_stats, busy, done, err),
//        decoder side (dec_data_in, dec_width, dec_en, dec_data_out, dec_num_of_error, dec_ready),
//        results (result_data, result_num_err, cnt_single, cnt_double)
module ecc_decode_ctrl
  import ecc_pkg::*;
#(
  parameter int AMBA_WORD = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            cw_width,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [DATA_WIDTH-1:0] noise,
  input  logic                  clr_stats,
  output logic                  busy,
  output logic [DATA_WIDTH-1:0] dec_data_in,
  output logic [AMBA_WORD-1:0]  dec_width,
  output logic                  dec_en,
  input  logic [DATA_WIDTH-1:0] dec_data_out,
  input  logic [1:0]            dec_num_of_error,
  input  logic                  dec_ready,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [1:0]            result_num_err,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           cnt_single,
  output logic [15:0]           cnt_double
);
  state_t state;
  logic [1:0] wid;
  logic [3:0] tcnt;
  logic cap;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      wid <= '0;
      tcnt <= '0;
      dec_data_in <= '0;
      result_data <= '0;
      result_num_err <= '0;
    end else begin
      case (state)
        ST_IDLE:
          if (start) begin
            wid <= cw_width;
            tcnt <= '0;
            if (cw_width == CW_ILL) state <= ST_ABORT;
            else begin
              dec_data_in <= (data_in ^ noise) & DATA_WIDTH'(width_mask(cw_width));
              state <= ST_ISSUE;
            end
          end
        ST_ISSUE:
          if (dec_ready) state <= ST_CAPTURE;
          else if (tcnt == 4'(TIMEOUT)) state <= ST_ABORT;
          else tcnt <= tcnt + 4'd1;
        ST_CAPTURE: begin
          result_data <= dec_data_out;
          result_num_err <= dec_num_of_error;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  // the Decoder only holds its outputs while enabled, so en stays up through CAPTURE
  assign dec_en = state == ST_ISSUE || state == ST_CAPTURE;
  assign busy = state != ST_IDLE;
  assign done = state == ST_DONE;
  assign err = state == ST_ABORT;
  assign dec_width = AMBA_WORD'(wid);
  assign cap = state == ST_CAPTURE;
  sat_counter16 u_single (
    .clk(clk),
    .reset(reset),
    .clr(clr_stats),
    .inc(cap && dec_num_of_error == NE_SINGLE),
    .count(cnt_single)
  );
  sat_counter16 u_double (
    .clk(clk),
    .reset(reset),
    .clr(clr_stats),
    .inc(cap && dec_num_of_error == NE_DOUBLE),
    .count(cnt_double)
  );
endmodule
